// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: buffer state encodings
// and the output buffer depth.
package fifo_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream.
// master: the reader block (pops the FIFO, presents the stream).
// slave:  the surrounding FIFO and downstream consumer.
interface fifo_stream_reader_if #(
   parameter int WIDTH = 8
);

   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rd_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty,
      input  fifo_rd_data,
      input  m_ready,
      output fifo_rd_en,
      output m_valid,
      output m_data
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_data,
      output m_ready,
      input  fifo_rd_en,
      input  m_valid,
      input  m_data
   );

endinterface

// File: rtl/fifo_stream_reader.sv
// Consumer-side adapter for the synchronous FIFO read port. Pops the FIFO
// (one-cycle read latency) and re-presents the words as a valid/ready
// stream through a head + skid buffer, sustaining one word per cycle.
// Optional feature macro: FIFO_RD_STATS_EN enables the delivered-word
// counter on pop_count; without it pop_count is tied to zero.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_stream_reader_if.master bus,
   output logic [CNT_W-1:0]     pop_count
);

   state_t           state_q;
   state_t           state_d;
   logic             inflight_q;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] head_d;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_d;
   logic             xfer;
   logic             arrival;
   logic [2:0]       level;

   assign bus.m_valid = (state_q != ST_EMPTY);
   assign bus.m_data  = head_q;
   assign xfer        = bus.m_valid & bus.m_ready;
   assign arrival     = inflight_q;

   // Occupancy the buffer will have to absorb: held words plus the word
   // in flight, minus the one leaving now. xfer implies occ>=1, so the
   // 3-bit sum cannot underflow.
   assign level = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, xfer};

   assign bus.fifo_rd_en = !rst && !bus.fifo_empty && (level < 3'(BUF_DEPTH));

   // Buffer state register, in-flight marker and data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         inflight_q <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= bus.fifo_rd_en;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

   // Capture arriving words and drain the head on downstream accept
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (arrival) begin
               head_d  = bus.fifo_rd_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (arrival && !xfer) begin
               skid_d  = bus.fifo_rd_data;
               state_d = ST_TWO;
            end else if (arrival && xfer) begin
               head_d  = bus.fifo_rd_data;
            end else if (xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // Arrival without xfer cannot happen here: the credit check
            // on fifo_rd_en never lets occ+inflight exceed two.
            if (xfer) begin
               head_d = skid_q;
               if (arrival) begin
                  skid_d = bus.fifo_rd_data;
               end else begin
                  state_d = ST_ONE;
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

`ifdef FIFO_RD_STATS_EN
   logic [CNT_W-1:0] pop_count_q;

   // Count words delivered downstream, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_count_q <= '0;
      end else if (xfer) begin
         pop_count_q <= pop_count_q + 1'b1;
      end
   end

   assign pop_count = pop_count_q;
`else
   assign pop_count = '0;
`endif

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(state_q == ST_TWO && arrival && !xfer));

   a_no_empty_pop: assert property (@(posedge clk)
      !(bus.fifo_rd_en && bus.fifo_empty));
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model on the read side,
// scoreboard queue filled as words are written into the FIFO and drained
// by a monitor whenever the stream transfers a word.
module tb_fifo_stream_reader;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             flush;
   logic [CNT_W-1:0] pop_count;

   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] exp_q[$];

   int tests    = 0;
   int failures = 0;

   fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

   fifo_stream_reader #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .pop_count (pop_count)
   );

   always #5 clk = ~clk;

   initial bus.fifo_empty = 1'b1;

   // Behavioural synchronous FIFO: registered read data, flush emulates its reset
   always @(posedge clk) begin
      if (flush) begin
         fq.delete();
         bus.fifo_empty <= 1'b1;
      end else begin
         if (bus.fifo_rd_en && fq.size() != 0) bus.fifo_rd_data <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
         bus.fifo_empty <= (fq.size() == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pop on transfer, hold-stability and empty-pop checks
   logic             hold_p = 1'b0;
   logic [WIDTH-1:0] hold_d = '0;
   initial begin
      logic [WIDTH-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (hold_p) begin
               check("hold_valid", 32'(bus.m_valid), 32'd1);
               check("hold_data", 32'(bus.m_data), 32'(hold_d));
            end
            if (bus.m_valid && bus.m_ready) begin
               if (exp_q.size() == 0) begin
                  check("sb_extra_word", 32'(bus.m_data), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_data", 32'(bus.m_data), 32'(e));
               end
            end
            if (bus.fifo_rd_en && bus.fifo_empty) begin
               check("pop_while_empty", 32'(bus.fifo_rd_en), 32'd0);
            end
         end
         hold_p = bus.m_valid && !bus.m_ready && !rst;
         hold_d = bus.m_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pops;
      int vcnt;
      int guard;
      logic [WIDTH-1:0] vdata;
      logic [CNT_W-1:0] exp_cnt;

      rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
      bus.m_ready = 1'b0;

      // Reset with FIFO being preloaded with 0x11..0x18
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            wr_en = 1'b1; wr_data = 8'h11 + 8'(i); exp_q.push_back(wr_data);
         end else begin
            wr_en = 1'b0;
         end
         tick();
         check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
         check("rst_m_valid", 32'(bus.m_valid), 32'd0);
         check("rst_m_data", 32'(bus.m_data), 32'd0);
         check("rst_pop_count", 32'(pop_count), 32'd0);
      end

      // Streaming 8 words with m_ready held high
      bus.m_ready = 1'b1;
      rst = 1'b0;
      #1;
      check("first_rd_en", 32'(bus.fifo_rd_en), 32'd1);
      tick();
      check("stream_lat_valid0", 32'(bus.m_valid), 32'd0);
      tick();
      check("stream_lat_valid1", 32'(bus.m_valid), 32'd1);
      check("stream_first_data", 32'(bus.m_data), 32'h11);
      for (int k = 1; k < 8; k++) begin
         tick();
         check("stream_valid", 32'(bus.m_valid), 32'd1);
         check("stream_data", 32'(bus.m_data), 32'h11 + 32'(k));
      end
      tick();
      check("stream_end_valid", 32'(bus.m_valid), 32'd0);
`ifdef FIFO_RD_STATS_EN
      exp_cnt = 16'd8;
`else
      exp_cnt = 16'd0;
`endif
      check("stream_pop_count", 32'(pop_count), 32'(exp_cnt));

      // Backpressure: three words, m_ready low
      bus.m_ready = 1'b0;
      pops = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 3) begin
            wr_en = 1'b1; wr_data = 8'h11 + 8'(c); exp_q.push_back(wr_data);
         end else begin
            wr_en = 1'b0;
         end
         if (bus.fifo_rd_en) pops++;
         tick();
      end
      check("bp_pops", 32'(pops), 32'd2);
      check("bp_valid", 32'(bus.m_valid), 32'd1);
      check("bp_data", 32'(bus.m_data), 32'h11);
      bus.m_ready = 1'b1;
      check("bp_rel0_data", 32'(bus.m_data), 32'h11);
      tick();
      check("bp_rel1_valid", 32'(bus.m_valid), 32'd1);
      check("bp_rel1_data", 32'(bus.m_data), 32'h12);
      tick();
      check("bp_rel2_valid", 32'(bus.m_valid), 32'd1);
      check("bp_rel2_data", 32'(bus.m_data), 32'h13);
      tick();
      check("bp_rel3_valid", 32'(bus.m_valid), 32'd0);

      // Empty boundary: a single word
      pops = 0; vcnt = 0; vdata = '0;
      for (int c = 0; c < 8; c++) begin
         if (c == 0) begin
            wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(wr_data);
         end else begin
            wr_en = 1'b0;
         end
         if (bus.fifo_rd_en) pops++;
         if (bus.m_valid) begin
            vcnt++; vdata = bus.m_data;
         end
         tick();
      end
      check("single_pops", 32'(pops), 32'd1);
      check("single_valid_cycles", 32'(vcnt), 32'd1);
      check("single_data", 32'(vdata), 32'hA5);

      // Random m_ready over 1000 words
      for (int i = 0; i < 1000; i++) begin
         wr_en = 1'b1; wr_data = 8'(i) ^ 8'h5A; exp_q.push_back(wr_data);
         bus.m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      wr_en = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 5000) begin
         bus.m_ready = 1'($urandom_range(0, 1));
         tick();
         guard++;
      end
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-stream with the buffer full
      bus.m_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(c); exp_q.push_back(wr_data);
         end else begin
            wr_en = 1'b0;
         end
         tick();
      end
      check("mid_pre_valid", 32'(bus.m_valid), 32'd1);
      check("mid_pre_data", 32'(bus.m_data), 32'h60);
      rst = 1'b1; flush = 1'b1;
      exp_q.delete();
      tick();
      check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
      check("mid_rst_pop_count", 32'(pop_count), 32'd0);
      check("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      rst = 1'b0; flush = 1'b0;
      bus.m_ready = 1'b1;
      wr_en = 1'b1; wr_data = 8'h50; exp_q.push_back(wr_data);
      tick();
      wr_en = 1'b0;
      guard = 0;
      while (!bus.m_valid && guard < 10) begin
         tick();
         guard++;
      end
      check("refill_valid", 32'(bus.m_valid), 32'd1);
      check("refill_data", 32'(bus.m_data), 32'h50);
      tick();
`ifdef FIFO_RD_STATS_EN
      exp_cnt = 16'd1;
`else
      exp_cnt = 16'd0;
`endif
      check("refill_pop_count", 32'(pop_count), 32'(exp_cnt));
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
